// File: rtl/mod_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sequencer
//  Purpose  : Steps two datapath operands (a, b) alternately. Each step waits
//             SETTLE cycles for the operand to propagate (DELAY), waits SETTLE
//             more cycles for the result to settle (SETTLE), then captures
//             {a, b, c} as a record and offers it on a valid/ready handshake
//             (EMIT). One iteration = a-step record + b-step record.
//  Ports    : clk, reset (sync, active-high)
//             start/count   - launch a run of 'count' iterations (IDLE only)
//             abort         - drop the run, return to IDLE, no done pulse
//             a, b / c      - operands to datapath / result from datapath
//             res_valid/res_ready, res_a/res_b/res_c - captured record
//             busy          - high in every state except IDLE
//             done          - one-cycle pulse at the end of a completed run
//  Options  : MOD_SEQ_TRACE_EN - when defined, prints "verilog <a> <b> <c>"
//             for every accepted record (simulation only)
//  Revision : 1.0 - initial release
// ============================================================================
module mod_sequencer #(
    parameter int A_WIDTH = 17,
    parameter int B_WIDTH = 5,
    parameter int C_WIDTH = 10,
    parameter int ITER_W  = 8,
    parameter int SETTLE  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ITER_W-1:0]  count,
    output logic [A_WIDTH-1:0] a,
    output logic [B_WIDTH-1:0] b,
    input  logic [C_WIDTH-1:0] c,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [A_WIDTH-1:0] res_a,
    output logic [B_WIDTH-1:0] res_b,
    output logic [C_WIDTH-1:0] res_c,
    output logic               busy,
    output logic               done
);

    // Timer counts SETTLE-1 down to 0, so it only needs to hold SETTLE-1.
    localparam int TIMER_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SETTLE - 1);

    localparam logic PH_A = 1'b0;
    localparam logic PH_B = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_SETTLE = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q;
    logic                 phase_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [ITER_W-1:0]    remaining_q;
    logic [ITER_W-1:0]    remaining_d;
    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic [A_WIDTH-1:0]   res_a_q;
    logic [B_WIDTH-1:0]   res_b_q;
    logic [C_WIDTH-1:0]   res_c_q;
    logic                 res_valid_q;
    logic                 busy_q;
    logic                 done_q;

    assign remaining_d = remaining_q - ITER_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_A;
            timer_q     <= '0;
            remaining_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_c_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            // Operands are deliberately left where they are so the datapath
            // state at the moment of abort can be inspected.
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        a_q         <= '0;
                        b_q         <= '0;
                        remaining_q <= count;
                        phase_q     <= PH_A;
                        timer_q     <= TIMER_LOAD;
                        busy_q      <= 1'b1;
                        if (count != '0) begin
                            state_q <= S_DELAY;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (timer_q == '0) begin
                        if (phase_q == PH_A) begin
                            a_q <= a_q + A_WIDTH'(1);
                        end else begin
                            b_q <= b_q + B_WIDTH'(1);
                        end
                        timer_q <= TIMER_LOAD;
                        state_q <= S_SETTLE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        res_a_q     <= a_q;
                        res_b_q     <= b_q;
                        res_c_q     <= c;
                        res_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        timer_q     <= TIMER_LOAD;
                        if (phase_q == PH_A) begin
                            phase_q <= PH_B;
                            state_q <= S_DELAY;
                        end else begin
                            remaining_q <= remaining_d;
                            if (remaining_d == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                phase_q <= PH_A;
                                state_q <= S_DELAY;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MOD_SEQ_TRACE_EN
    // Mirrors the acceptance condition of the FSM: abort pre-empts a handshake.
    always @(posedge clk) begin
        if (!reset && !abort && (state_q == S_EMIT) && res_valid_q && res_ready) begin
            $display("verilog %0d %0d %0d", res_a_q, res_b_q, res_c_q);
        end
    end
`else
    // Trace disabled: no simulation-only code is compiled.
`endif

    assign a         = a_q;
    assign b         = b_q;
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;
    assign res_c     = res_c_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_sequencer
//  Purpose  : Directed self-checking bench for mod_sequencer with a modelled
//             datapath c = a + b (truncated to the c width).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_sequencer;

    localparam int A_W = 17;
    localparam int B_W = 5;
    localparam int C_W = 10;
    localparam int I_W = 8;
    localparam int ST  = 10;
    localparam int GAP = 2 * ST + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [I_W-1:0] count;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    logic           res_valid;
    logic           res_ready;
    logic [A_W-1:0] res_a;
    logic [B_W-1:0] res_b;
    logic [C_W-1:0] res_c;
    logic           busy;
    logic           done;

    int n_total  = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    mod_sequencer #(
        .A_WIDTH (A_W),
        .B_WIDTH (B_W),
        .C_WIDTH (C_W),
        .ITER_W  (I_W),
        .SETTLE  (ST)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .count     (count),
        .a         (a),
        .b         (b),
        .c         (c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_a     (res_a),
        .res_b     (res_b),
        .res_c     (res_c),
        .busy      (busy),
        .done      (done)
    );

    // Datapath model
    assign c = C_W'(a + A_W'(b));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (res_valid) ok = 1'b1;
        end
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        count = I_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full run with res_ready=1: checks every record, optional record spacing,
    // and a single done pulse followed by busy=0.
    task automatic run_full(input int n, input bit chk_gap);
        int  base, cyc, it, ea, eb;
        bit  ok;
        base = done_cnt;
        res_ready = 1'b1;
        pulse_start(n);
        check("busy_after_start", busy, 1);
        for (int r = 0; r < 2 * n; r++) begin
            wait_valid(100, cyc, ok);
            if (!ok) begin
                check("rec_timeout", 0, 1);
                return;
            end
            it = r / 2 + 1;
            ea = it;
            eb = ((r % 2) == 0 ? it - 1 : it) % 32;
            check("res_a", res_a, ea);
            check("res_b", res_b, eb);
            check("res_c", res_c, (ea + eb) % 1024);
            if (chk_gap && r > 0) check("rec_gap", cyc, GAP);
        end
        ok = 1'b0;
        for (int k = 0; k < 5 && !ok; k++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check("done_seen", ok, 1);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("busy_end", busy, 0);
        check("done_pulses", done_cnt - base, 1);
    endtask

    initial begin
        int  cyc, base;
        bit  ok;
        reset = 1'b1; start = 1'b0; abort = 1'b0; count = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", res_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_res_a", res_a, 0);
        check("rst_res_b", res_b, 0);
        check("rst_res_c", res_c, 0);

        // Nominal run of 5 iterations
        run_full(5, 1'b1);

        // Zero-count run
        base = done_cnt;
        pulse_start(0);
        check("cnt0_done", done, 1);
        check("cnt0_valid", res_valid, 0);
        check("cnt0_a", a, 0);
        check("cnt0_b", b, 0);
        @(negedge clk);
        check("cnt0_done_low", done, 0);
        check("cnt0_busy_low", busy, 0);
        check("cnt0_pulses", done_cnt - base, 1);

        // abort together with start in IDLE: abort wins
        start = 1'b1; abort = 1'b1; count = I_W'(3);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", busy, 0);

        // Back-pressure on the first record
        res_ready = 1'b0;
        pulse_start(2);
        wait_valid(100, cyc, ok);
        check("bp_first_seen", ok, 1);
        for (int k = 0; k < 7; k++) begin
            check("bp_valid_hold", res_valid, 1);
            check("bp_res_a", res_a, 1);
            check("bp_res_b", res_b, 0);
            check("bp_res_c", res_c, 1);
            check("bp_a_hold", a, 1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_valid(100, cyc, ok);
        check("bp_second_seen", ok, 1);
        check("bp_next_gap", cyc, GAP);
        check("bp_second_b", res_b, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("bp_abort_busy", busy, 0);

        // Abort during SETTLE of iteration 3, a-step
        base = done_cnt;
        res_ready = 1'b1;
        pulse_start(5);
        for (int r = 0; r < 4; r++) wait_valid(100, cyc, ok);
        check("ab_fourth_seen", ok, 1);
        repeat (15) @(negedge clk);
        check("ab_in_settle_a", a, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_valid", res_valid, 0);
        check("ab_a", a, 3);
        check("ab_b", b, 2);
        repeat (30) @(negedge clk);
        check("ab_no_done", done_cnt - base, 0);
        check("ab_still_idle", busy, 0);

        // Reset in EMIT with a pending record
        res_ready = 1'b0;
        pulse_start(3);
        wait_valid(100, cyc, ok);
        check("rs_emit_seen", ok, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rs_valid", res_valid, 0);
        check("rs_busy", busy, 0);
        check("rs_a", a, 0);
        check("rs_res_a", res_a, 0);
        check("rs_res_c", res_c, 0);
        run_full(1, 1'b0);

        // Long run with b wrap-around
        run_full(40, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_sequencer.md
MOD_SEQUENCER -- requirements
Module: mod_sequencer

Interface
REQ-001 SHALL have parameters: A_WIDTH, default 17, operand a width; B_WIDTH, default 5, operand b width; C_WIDTH, default 10, result c width; ITER_W, default 8, iteration count width; SETTLE, default 10, delay/settle cycles per step (>=1).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run, sampled in IDLE only.
- abort  in  1  terminate the run.
- count  in  ITER_W  iterations per run, sampled with start.
- a  out  A_WIDTH  operand a to datapath.
- b  out  B_WIDTH  operand b to datapath.
- c  in  C_WIDTH  datapath result.
- res_valid  out  1  record available.
- res_ready  in  1  consumer accepts record.
- res_a  out  A_WIDTH  captured a.
- res_b  out  B_WIDTH  captured b.
- res_c  out  C_WIDTH  captured c.
- busy  out  1  run in progress.
- done  out  1  one-cycle run-complete pulse.

Function
REQ-003 SHALL implement states IDLE, DELAY, SETTLE, EMIT, DONE, plus a phase bit (PH_A/PH_B) and a down-counting timer.
REQ-004 IDLE: start=1 and abort=0 -> a<=0, b<=0, remaining<=count, phase<=PH_A; next state is DELAY if count!=0, else DONE.
REQ-005 DELAY SHALL last exactly SETTLE cycles; on exit, PH_A increments a and PH_B increments b (modulo 2^width, wrap without flag), then enter SETTLE.
REQ-006 SETTLE SHALL last exactly SETTLE cycles; on exit, res_a<=a, res_b<=b, res_c<=c, res_valid<=1, then enter EMIT.
REQ-007 EMIT SHALL hold res_valid and res_a/b/c stable, and a/b unchanged, until res_valid&&res_ready; on that cycle res_valid<=0.
REQ-008 On EMIT acceptance: PH_A -> phase<=PH_B, go to DELAY; PH_B -> remaining decremented; if the result is 0 go to DONE, else phase<=PH_A and go to DELAY.
REQ-009 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-010 busy SHALL be 1 in every state except IDLE; done SHALL be 0 outside DONE.
REQ-011 Each iteration SHALL emit exactly two records (after a step, after b step); a run of N emits 2N records.
REQ-012 Minimum cycles per record SHALL be 2*SETTLE+1.
REQ-013 start while busy SHALL be ignored; count SHALL be sampled only on accepted start.
REQ-014 abort=1 in any non-IDLE state -> next state IDLE, res_valid<=0, no done pulse, a/b retain values.
REQ-015 abort=1 and start=1 together in IDLE -> abort wins, state stays IDLE.

Reset
REQ-016 reset=1 SHALL, at the next clk edge, force IDLE, phase PH_A, timer 0, remaining 0, a=0, b=0, res_a=res_b=res_c=0, res_valid=0, busy=0, done=0.
REQ-017 Reset SHALL take priority over start, abort and an in-flight handshake, including mid-EMIT.

Configuration
REQ-018 With MOD_SEQ_TRACE_EN defined, the block SHALL print "verilog <a> <b> <c>" (decimal, from res_a, res_b, res_c) in simulation once per accepted record; without it, no display code SHALL be compiled and behaviour SHALL be otherwise identical.

Verification
REQ-019 Reset, count=5, SETTLE=10, res_ready=1, model c=a+b -> 10 records (1,0,1),(1,1,2),(2,1,3),(2,2,4) ... (5,5,10), then one done pulse, busy=0.
REQ-020 count=0 start -> DONE next cycle, done=1 for one cycle, no res_valid, a=b=0.
REQ-021 res_ready=0 for 7 cycles on the first record -> res_valid held, res_a=1, res_b=0, res_c=1 stable, a stays 1, next DELAY starts the cycle after acceptance.
REQ-022 abort during the SETTLE of iteration 3, PH_A -> IDLE next cycle, busy=0, res_valid=0, done never asserted, a=3, b=2 held.
REQ-023 count=40, B_WIDTH=5 -> b wraps 31->0 at iteration 32, 80 records total, done pulse once.
REQ-024 reset asserted in EMIT with res_valid=1 -> next cycle all outputs 0 and state IDLE; a subsequent start runs normally from a=b=0.
